uart_rx: RTL and testbench



---
 rtl/uart_pkg.sv | 26 ++
 rtl/sync_2ff.sv | 26 ++
 rtl/uart_rx.sv | 136 +++++++++++++
 tb/tb_uart_rx.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: state encoding and frame constants, also used by uart_tx.
package uart_pkg;

   localparam logic [2:0] IDLE  = 3'd0;
   localparam logic [2:0] START = 3'd1;
   localparam logic [2:0] DATA  = 3'd2;
   localparam logic [2:0] STOP  = 3'd3;
   localparam logic [2:0] BREAK = 3'd4;

   localparam int unsigned DATA_BITS = 8;
   localparam int unsigned STOP_BITS = 1;

   typedef enum logic [2:0] {
      StIdle  = IDLE,
      StStart = START,
      StData  = DATA,
      StStop  = STOP,
      StBreak = BREAK
   } uart_state_e;

   // Last counter value of the half-bit wait before the start-bit sample.
   function automatic logic [15:0] half_bit_last(input int unsigned clks_per_bit);
      return 16'((clks_per_bit / 2) - 1);
   endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous level, with configurable reset value.
module sync_2ff #(
   parameter logic RESET_VAL = 1'b1
) (
   input  logic clk,
   input  logic reset,
   input  logic d,
   output logic q
);

   logic meta_q;
   logic sync_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         meta_q <= RESET_VAL;
         sync_q <= RESET_VAL;
      end else begin
         meta_q <= d;
         sync_q <= meta_q;
      end
   end

   assign q = sync_q;

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: mid-bit sampling, one-cycle rx_done/frame_err strobes, BREAK lockout.
module uart_rx
   import uart_pkg::*;
#(
   parameter int unsigned CLKS_PER_BIT = 868
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       rx,
   output logic [7:0] dout,
   output logic       rx_done,
   output logic       frame_err,
   output logic       busy
);

   localparam logic [15:0] BitLast  = 16'(CLKS_PER_BIT - 1);
   localparam logic [15:0] HalfLast = half_bit_last(CLKS_PER_BIT);
   localparam logic [2:0]  IdxLast  = 3'(DATA_BITS - 1);

   logic rx_s;

   uart_state_e state_q, state_d;
   logic [15:0] ctr_q, ctr_d;
   logic [2:0]  bit_idx_q, bit_idx_d;
   logic [7:0]  shreg_q, shreg_d;
   logic [7:0]  dout_q, dout_d;
   logic        rx_done_q, rx_done_d;
   logic        frame_err_q, frame_err_d;

   sync_2ff #(
      .RESET_VAL(1'b1)
   ) u_sync_rx (
      .clk  (clk),
      .reset(reset),
      .d    (rx),
      .q    (rx_s)
   );

   always_comb begin
      state_d     = state_q;
      ctr_d       = ctr_q;
      bit_idx_d   = bit_idx_q;
      shreg_d     = shreg_q;
      dout_d      = dout_q;
      rx_done_d   = 1'b0;
      frame_err_d = 1'b0;

      case (state_q)
         StIdle: begin
            ctr_d = '0;
            if (!rx_s) state_d = StStart;
         end

         StStart: begin
            if (ctr_q == HalfLast) begin
               ctr_d     = '0;
               bit_idx_d = '0;
               // A high line at mid start bit was only a glitch.
               state_d   = rx_s ? StIdle : StData;
            end else begin
               ctr_d = ctr_q + 16'd1;
            end
         end

         StData: begin
            if (ctr_q == BitLast) begin
               ctr_d            = '0;
               shreg_d[bit_idx_q] = rx_s;
               if (bit_idx_q == IdxLast) begin
                  state_d = StStop;
               end else begin
                  bit_idx_d = bit_idx_q + 3'd1;
               end
            end else begin
               ctr_d = ctr_q + 16'd1;
            end
         end

         StStop: begin
            if (ctr_q == BitLast) begin
               ctr_d = '0;
               if (rx_s) begin
                  dout_d    = shreg_q;
                  rx_done_d = 1'b1;
                  state_d   = StIdle;
               end else begin
                  frame_err_d = 1'b1;
                  state_d     = StBreak;
               end
            end else begin
               ctr_d = ctr_q + 16'd1;
            end
         end

         StBreak: begin
            // Hold off until the line returns high so a stuck-low line is not parsed as 0x00s.
            ctr_d = '0;
            if (rx_s) state_d = StIdle;
         end

         default: begin
            state_d = StIdle;
            ctr_d   = '0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= StIdle;
         ctr_q       <= '0;
         bit_idx_q   <= '0;
         shreg_q     <= '0;
         dout_q      <= '0;
         rx_done_q   <= 1'b0;
         frame_err_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         ctr_q       <= ctr_d;
         bit_idx_q   <= bit_idx_d;
         shreg_q     <= shreg_d;
         dout_q      <= dout_d;
         rx_done_q   <= rx_done_d;
         frame_err_q <= frame_err_d;
      end
   end

   assign dout      = dout_q;
   assign rx_done   = rx_done_q;
   assign frame_err = frame_err_q;
   assign busy      = (state_q != StIdle);

   a_strobe_excl: assert property (@(posedge clk) disable iff (reset)
      !(rx_done_q && frame_err_q));

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx at CLKS_PER_BIT = 16 with a time-based serial driver.
`timescale 1ns / 1ps
module tb_uart_rx;

   localparam int unsigned Cpb   = 16;
   localparam realtime     ClkNs = 10.0;
   localparam realtime     BitNs = 160.0;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       rx = 1'b1;
   logic [7:0] dout;
   logic       rx_done;
   logic       frame_err;
   logic       busy;

   typedef struct packed {
      logic       is_err;
      logic [7:0] data;
   } exp_t;

   exp_t      exp_q[$];
   realtime   done_times[$];
   logic [127:0] blk;
   int        checks = 0;
   int        errors = 0;
   int        done_total = 0;
   int        err_total = 0;

   int first_done, done_cnt, busy_cnt, first_busy, strobe_cnt;
   int d0, e0, bad_gaps;

   uart_rx #(
      .CLKS_PER_BIT(Cpb)
   ) dut (
      .clk      (clk),
      .reset    (reset),
      .rx       (rx),
      .dout     (dout),
      .rx_done  (rx_done),
      .frame_err(frame_err),
      .busy     (busy)
   );

   always #(ClkNs / 2) clk = ~clk;

   task automatic check(input string name, input logic [127:0] got, input logic [127:0] want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, got, want);
      end
   endtask

   task automatic send_frame(input logic [7:0] b, input logic stop_bit, input realtime bit_t);
      rx = 1'b0;
      #(bit_t);
      for (int i = 0; i < 8; i++) begin
         rx = b[i];
         #(bit_t);
      end
      rx = stop_bit;
      #(bit_t);
   endtask

   task automatic push(input logic is_err, input logic [7:0] data);
      exp_t e;
      e.is_err = is_err;
      e.data   = data;
      exp_q.push_back(e);
   endtask

   // Monitor: pops one expectation per strobe.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (rx_done && frame_err) check("strobes_exclusive", 1, 0);
         if (rx_done || frame_err) begin
            if (rx_done) begin
               done_total++;
               done_times.push_back($realtime);
               blk = {blk[119:0], dout};
            end
            if (frame_err) err_total++;
            if (exp_q.size() == 0) begin
               check("unexpected_strobe", {rx_done, frame_err, dout}, 0);
            end else begin
               e = exp_q.pop_front();
               check(e.is_err ? "ferr_dout_held" : "rx_byte",
                     {frame_err, dout}, {e.is_err, e.data});
            end
         end
      end
   end

   initial begin
      #5ms;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      blk = '0;
      repeat (4) @(posedge clk);
      #1;
      check("reset_dout", dout, 8'h00);
      check("reset_rx_done", rx_done, 0);
      check("reset_frame_err", frame_err, 0);
      check("reset_busy", busy, 0);
      reset = 1'b0;
      repeat (20) @(posedge clk);
      #1;

      // Frame 0xA5 with cycle-exact timing: strobe 155 clocks after the pin edge.
      first_done = -1; done_cnt = 0; busy_cnt = 0; first_busy = -1;
      push(1'b0, 8'hA5);
      fork
         send_frame(8'hA5, 1'b1, BitNs);
         begin
            for (int n = 1; n <= 170; n++) begin
               @(posedge clk);
               #1;
               if (rx_done) begin
                  done_cnt++;
                  if (first_done < 0) first_done = n;
               end
               if (busy) begin
                  busy_cnt++;
                  if (first_busy < 0) first_busy = n;
               end
            end
         end
      join
      check("a5_strobe_clock", first_done, 155);
      check("a5_strobe_count", done_cnt, 1);
      check("a5_busy_cycles", busy_cnt, 152);
      check("a5_busy_first", first_busy, 3);
      #(2 * BitNs);

      // 3-cycle glitch: busy for 8 cycles, no strobes.
      @(posedge clk);
      #1;
      busy_cnt = 0; strobe_cnt = 0;
      fork
         begin
            rx = 1'b0;
            #(3 * ClkNs);
            rx = 1'b1;
         end
         begin
            for (int n = 1; n <= 40; n++) begin
               @(posedge clk);
               #1;
               if (busy) busy_cnt++;
               if (rx_done || frame_err) strobe_cnt++;
            end
         end
      join
      check("glitch_busy_cycles", busy_cnt, 8);
      check("glitch_no_strobe", strobe_cnt, 0);

      // Stop bit low then line held low: one frame_err, dout stays 0xA5.
      d0 = done_total; e0 = err_total;
      push(1'b1, 8'hA5);
      send_frame(8'h3C, 1'b0, BitNs);
      #(40 * ClkNs);
      check("break_ferr_once", err_total - e0, 1);
      check("break_no_done", done_total - d0, 0);
      check("break_busy", busy, 1);
      check("break_dout_held", dout, 8'hA5);
      rx = 1'b1;
      #(2 * BitNs);
      check("break_exit_idle", busy, 0);
      push(1'b0, 8'h7E);
      send_frame(8'h7E, 1'b1, BitNs);
      #(2 * BitNs);

      // 16 back-to-back frames, zero idle bits.
      done_times.delete();
      blk = '0;
      for (int i = 0; i < 16; i++) push(1'b0, 8'(i));
      for (int i = 0; i < 16; i++) send_frame(8'(i), 1'b1, BitNs);
      #(2 * BitNs);
      check("b2b_count", done_times.size(), 16);
      bad_gaps = 0;
      for (int i = 1; i < done_times.size(); i++)
         if (done_times[i] - done_times[i-1] != BitNs * 10) bad_gaps++;
      check("b2b_spacing", bad_gaps, 0);
      check("b2b_block", blk, 128'h000102030405060708090A0B0C0D0E0F);

      // Reset pulse during data bit 4 of 0xFF.
      d0 = done_total; e0 = err_total;
      @(posedge clk);
      #1;
      fork
         send_frame(8'hFF, 1'b1, BitNs);
         begin
            repeat (85) @(posedge clk);
            #1;
            reset = 1'b1;
            @(posedge clk);
            #1;
            reset = 1'b0;
            check("midrst_dout", dout, 8'h00);
            check("midrst_busy", busy, 0);
            check("midrst_strobes", {rx_done, frame_err}, 2'b00);
         end
      join
      #(2 * BitNs);
      check("midrst_no_strobe", (done_total - d0) + (err_total - e0), 0);
      push(1'b0, 8'h81);
      send_frame(8'h81, 1'b1, BitNs);
      #(2 * BitNs);
      check("after_rst_dout", dout, 8'h81);

      // Transmitter 2% fast, then 2% slow.
      push(1'b0, 8'h55);
      send_frame(8'h55, 1'b1, BitNs * 0.98);
      #(2 * BitNs);
      push(1'b0, 8'hAA);
      send_frame(8'hAA, 1'b1, BitNs * 0.98);
      #(2 * BitNs);
      push(1'b0, 8'h55);
      send_frame(8'h55, 1'b1, BitNs * 1.02);
      #(2 * BitNs);
      push(1'b0, 8'hAA);
      send_frame(8'hAA, 1'b1, BitNs * 1.02);
      #(3 * BitNs);

      check("scoreboard_drained", exp_q.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
